// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - parametrised instruction-fetch PC with program table, branches, stall and halt
// Optional return-address stack for call/return is compiled in when FETCH_RAS_EN is defined.
module fetch_unit #(
  parameter int                          PC_W        = 10,
  parameter int                          NUM_PROGS   = 2,
  parameter int                          PS_W        = 1,
  parameter logic [NUM_PROGS*PC_W-1:0]   START_ADDRS = {10'd52, 10'd0},
  parameter logic [NUM_PROGS*PC_W-1:0]   END_ADDRS   = {10'd134, 10'd51},
  parameter int                          RAS_DEPTH   = 4
) (
  input  logic            CLK,
  input  logic            Init,
  input  logic [PS_W-1:0] ProgSel,
  input  logic            Stall,
  input  logic            Branch_en,
  input  logic            FLAG_IN,
  input  logic            BranchRel,
  input  logic [PC_W-1:0] Target,
  input  logic            Call_en,
  input  logic            Ret_en,
  output logic [PC_W-1:0] PC,
  output logic            Halt,
  output logic            StackErr
);

  // Out-of-range program selects fall back to entry 0.
  function automatic logic [PS_W-1:0] sel_idx(input logic [PS_W-1:0] s);
    sel_idx = (32'(s) < NUM_PROGS) ? s : '0;
  endfunction

  function automatic logic [PC_W-1:0] addr_at(input logic [NUM_PROGS*PC_W-1:0] tbl,
                                              input logic [PS_W-1:0] idx);
    addr_at = tbl[PC_W-1:0];
    for (int i = 1; i < NUM_PROGS; i++) begin
      if (32'(idx) == i) addr_at = tbl[i*PC_W +: PC_W];
    end
  endfunction

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc, tgt, end_pc;
  logic [PS_W-1:0] prog_q, init_sel;
  logic            halt_q, halt_d;

  assign init_sel = sel_idx(ProgSel);
  assign pc_inc   = pc_q + PC_W'(1);
  assign tgt      = BranchRel ? (pc_q + Target) : Target;
  assign end_pc   = addr_at(END_ADDRS, prog_q);

`ifdef FETCH_RAS_EN
  localparam int SP_W  = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             err_q, err_d;
  logic             push_en;
  logic [IDX_W-1:0] top_idx, push_idx;

  assign push_idx = IDX_W'(sp_q);
  assign top_idx  = IDX_W'(sp_q - SP_W'(1));
`endif

  always_comb begin
    pc_d   = pc_q;
    halt_d = halt_q;
`ifdef FETCH_RAS_EN
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
`endif
    if (halt_q || Stall) begin
      pc_d = pc_q;
    end else if (pc_q == end_pc) begin
      // End of program wins over any control-flow request this cycle.
      halt_d = 1'b1;
`ifdef FETCH_RAS_EN
    end else if (Ret_en) begin
      if (sp_q == '0) begin
        err_d = 1'b1;
        pc_d  = pc_inc;
      end else begin
        pc_d = ras_q[top_idx];
        sp_d = sp_q - SP_W'(1);
      end
    end else if (Call_en) begin
      pc_d = tgt;
      if (sp_q == SP_W'(RAS_DEPTH)) begin
        err_d = 1'b1;
      end else begin
        push_en = 1'b1;
        sp_d    = sp_q + SP_W'(1);
      end
`endif
    end else if (Branch_en && FLAG_IN) begin
      pc_d = tgt;
    end else begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge CLK) begin
    if (Init) begin
      pc_q   <= addr_at(START_ADDRS, init_sel);
      prog_q <= init_sel;
      halt_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      halt_q <= halt_d;
    end
  end

`ifdef FETCH_RAS_EN
  always_ff @(posedge CLK) begin
    if (Init) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack contents survive Init; only the pointer is reset.
  always_ff @(posedge CLK) begin
    if (!Init && push_en) ras_q[push_idx] <= pc_inc;
  end

  assign StackErr = err_q;
`else
  logic unused_ras;
  assign unused_ras = Call_en ^ Ret_en;
  assign StackErr   = 1'b0;
`endif

  assign PC   = pc_q;
  assign Halt = halt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a behavioural model
module tb_fetch_unit;

`ifdef FETCH_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic       clk;
  logic       init, stall, br, flag, rel, call, ret;
  logic [0:0] progsel;
  logic [9:0] target;
  logic [9:0] pc;
  logic       halt, stack_err;

  logic       s_init;
  logic [0:0] s_progsel;
  logic [3:0] s_target;
  logic       s_zero;
  logic [3:0] s_pc;
  logic       s_halt, s_err;

  int checks = 0;
  int errors = 0;

  int m_pc, m_prog;
  bit m_halt, m_err;
  int m_stack[$];
  int start_tab[2] = '{0, 52};
  int end_tab[2]   = '{51, 134};

  fetch_unit u_dut (
    .CLK(clk), .Init(init), .ProgSel(progsel), .Stall(stall), .Branch_en(br),
    .FLAG_IN(flag), .BranchRel(rel), .Target(target), .Call_en(call), .Ret_en(ret),
    .PC(pc), .Halt(halt), .StackErr(stack_err)
  );

  fetch_unit #(
    .PC_W(4), .NUM_PROGS(1), .PS_W(1), .START_ADDRS(4'hE), .END_ADDRS(4'h3), .RAS_DEPTH(4)
  ) u_small (
    .CLK(clk), .Init(s_init), .ProgSel(s_progsel), .Stall(s_zero), .Branch_en(s_zero),
    .FLAG_IN(s_zero), .BranchRel(s_zero), .Target(s_target), .Call_en(s_zero), .Ret_en(s_zero),
    .PC(s_pc), .Halt(s_halt), .StackErr(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wrap(int v);
    return ((v % 1024) + 1024) % 1024;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int t, off;
    off = (target >= 10'd512) ? int'(target) - 1024 : int'(target);
    t   = rel ? wrap(m_pc + off) : int'(target);
    if (init) begin
      m_prog = int'(progsel);
      m_pc   = start_tab[m_prog];
      m_halt = 1'b0;
      m_err  = 1'b0;
      m_stack.delete();
    end else if (m_halt || stall) begin
      m_pc = m_pc;
    end else if (m_pc == end_tab[m_prog]) begin
      m_halt = 1'b1;
    end else if (RAS_ON && ret) begin
      if (m_stack.size() == 0) begin
        m_err = 1'b1;
        m_pc  = wrap(m_pc + 1);
      end else begin
        m_pc = m_stack.pop_back();
      end
    end else if (RAS_ON && call) begin
      if (m_stack.size() == 4) m_err = 1'b1;
      else m_stack.push_back(wrap(m_pc + 1));
      m_pc = t;
    end else if (br && flag) begin
      m_pc = t;
    end else begin
      m_pc = wrap(m_pc + 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_pc", pc, m_pc);
    check("model_halt", halt, m_halt);
    check("model_stackerr", stack_err, m_err);
  endtask

  task automatic idle();
    init = 0; stall = 0; br = 0; flag = 0; rel = 0; call = 0; ret = 0;
    progsel = 0; target = 0;
  endtask

  task automatic jump_abs(input int a);
    idle(); br = 1; flag = 1; target = 10'(a);
    tick();
    idle();
  endtask

  initial begin
    logic [3:0] seq[5];
    seq = '{4'hF, 4'h0, 4'h1, 4'h2, 4'h3};
    s_init = 0; s_progsel = 0; s_target = 0; s_zero = 0;
    idle();

    // Reset state
    init = 1; progsel = 0;
    tick();
    check("reset_pc", pc, 0);
    check("reset_halt", halt, 0);
    check("reset_err", stack_err, 0);
    idle();
    for (int i = 0; i < 10; i++) tick();
    check("pc10", pc, 10);

    // Relative branch taken, then not taken
    br = 1; flag = 1; rel = 1; target = 10'h3FC;
    tick();
    check("rel_branch", pc, 6);
    jump_abs(10);
    br = 1; flag = 0; rel = 1; target = 10'h3FC;
    tick();
    check("not_taken", pc, 11);

    // Stall holds PC, branch taken once released
    jump_abs(20);
    br = 1; flag = 1; target = 10'd3; stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", pc, 20);
    end
    stall = 0;
    tick();
    check("after_stall", pc, 3);

    // Return on empty stack
    idle(); init = 1; tick(); idle();
    jump_abs(7);
    ret = 1; tick(); idle();
    check("ret_empty_pc", pc, 8);
    check("ret_empty_err", stack_err, RAS_ON);

    // Call then return
    init = 1; tick(); idle();
    jump_abs(5);
    call = 1; target = 10'd40; tick(); idle();
    check("call_pc", pc, RAS_ON ? 40 : 6);
    tick();
    ret = 1; tick(); idle();
    check("ret_pc", pc, RAS_ON ? 6 : 8);
    check("ret_err", stack_err, 0);

    // Five nested calls overflow a 4-deep stack
    for (int i = 0; i < 5; i++) begin
      call = 1; target = 10'(20 + 5 * i); tick();
    end
    idle();
    check("overflow_jump", pc, RAS_ON ? 40 : 13);
    check("overflow_err", stack_err, RAS_ON);
    for (int i = 0; i < 5; i++) begin
      ret = 1; tick();
    end
    idle();

    // Program 1 runs to its end and halts
    init = 1; progsel = 1; tick(); idle();
    check("prog1_start", pc, 52);
    for (int i = 0; i < 82; i++) tick();
    check("at_end_pc", pc, 134);
    check("at_end_halt", halt, 0);
    tick();
    check("halt_rise", halt, 1);
    check("halt_pc", pc, 134);
    br = 1; flag = 1; target = 10'd0;
    tick(); tick();
    check("halted_frozen", pc, 134);
    idle();
    init = 1; tick(); idle();
    check("restart_pc", pc, 0);
    check("restart_halt", halt, 0);
    tick();
    check("restart_fetch", pc, 1);

    // End-of-program beats a branch on the same cycle
    jump_abs(50);
    tick();
    br = 1; flag = 1; target = 10'd0; tick(); idle();
    check("end_beats_branch_halt", halt, 1);
    check("end_beats_branch_pc", pc, 51);

    // Narrow PC wraps from 0xF to 0x0
    s_init = 1; tick(); s_init = 0;
    check("small_start", s_pc, 4'hE);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("small_seq", s_pc, seq[i]);
      check("small_nohalt", s_halt, 0);
    end
    tick();
    check("small_halt", s_halt, 1);
    check("small_halt_pc", s_pc, 4'h3);
    s_init = 1; tick(); s_init = 0;
    check("small_reinit_pc", s_pc, 4'hE);
    check("small_reinit_halt", s_halt, 0);

    // Randomized traffic against the model
    init = 1; tick(); idle();
    for (int i = 0; i < 400; i++) begin
      init    = ($urandom_range(0, 39) == 0);
      progsel = 1'($urandom_range(0, 1));
      stall   = ($urandom_range(0, 4) == 0);
      br      = ($urandom_range(0, 2) == 0);
      flag    = 1'($urandom_range(0, 1));
      rel     = 1'($urandom_range(0, 1));
      call    = ($urandom_range(0, 7) == 0);
      ret     = ($urandom_range(0, 7) == 0);
      target  = rel ? 10'(int'($urandom_range(0, 16)) - 8) : 10'($urandom_range(0, 140));
      tick();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch program counter for the basic processor. Sits at the front of the datapath, driving the instruction-memory address, and generalises the fixed-width two-program fetcher. Adds a configurable PC width, a table of N program start/end addresses, absolute or PC-relative conditional branches, stall, a sticky halt, and an optional return-address stack for call/return.

## Interface
Parameters:
- PC_W, 10, PC and target width in bits
- NUM_PROGS, 2, number of selectable programs
- PS_W, 1, ProgSel width; must be ≥ clog2(NUM_PROGS), minimum 1
- START_ADDRS, {10'd52, 10'd0}, packed NUM_PROGS×PC_W start addresses; entry i is bits [i*PC_W +: PC_W]
- END_ADDRS, {10'd134, 10'd51}, packed NUM_PROGS×PC_W last-instruction addresses
- RAS_DEPTH, 4, return-address stack entries (≥1)

Ports:
- CLK  in  1  clock; all state changes on the rising edge only
- Init  in  1  synchronous, active-high reset / program load
- ProgSel  in  PS_W  program select, sampled only while Init=1
- Stall  in  1  hold PC and all state this cycle
- Branch_en  in  1  conditional branch request
- FLAG_IN  in  1  branch condition; taken iff Branch_en & FLAG_IN
- BranchRel  in  1  0: Target is absolute; 1: Target is signed offset from PC
- Target  in  PC_W  branch/call target or offset
- Call_en  in  1  unconditional call (target formed as for branch)
- Ret_en  in  1  return to popped address
- PC  out  PC_W  registered program counter
- Halt  out  1  sticky done flag
- StackErr  out  1  sticky RAS overflow/underflow flag

## Operation
- Init=1: PC ← START[ProgSel]; prog_q ← ProgSel; Halt ← 0; StackErr ← 0; stack pointer ← 0. ProgSel ≥ NUM_PROGS selects entry 0.
- Init=0: one action per cycle, in priority order:
  1. Halt=1: everything frozen until Init.
  2. Stall=1: everything held.
  3. PC == END[prog_q]: Halt ← 1; PC held. This takes priority over branch, call and return on the same cycle.
  4. Ret_en: pop into PC. If the stack is empty, StackErr ← 1 and PC ← PC+1.
  5. Call_en: PC ← tgt; push PC+1. If the stack is full, the push is dropped, StackErr ← 1, and the jump still occurs.
  6. Branch_en & FLAG_IN: PC ← tgt.
  7. Otherwise: PC ← PC+1.
- tgt = BranchRel ? PC + Target, with Target as two's complement : Target.
- All PC arithmetic is modulo 2^PC_W. All-ones + 1 wraps to 0 with no flag.
- Branch_en with FLAG_IN=0 is a normal increment.
- RAS: LIFO with pointer 0..RAS_DEPTH. Contents are not cleared by Init; the pointer reset is sufficient.

## Timing
- Reset values: PC=START[0] after power-up initialisation (PC=0 with default parameters), Halt=0, StackErr=0.
- PC is registered. A request in cycle n is visible on PC in cycle n+1; there are no combinational paths from inputs to outputs.
- Halt rises in the cycle after PC is first presented at END[prog_q]; PC still shows END in that cycle.
- Init asserted mid-program, mid-stall or while halted takes effect at the next edge, with identical results.
- StackErr, once set, stays set until Init.
- Halt-to-Init restart latency is 1 cycle: first fetch at START in the cycle after Init falls.

## Configuration
- FETCH_RAS_EN defined: the return-address stack and Call_en/Ret_en handling (priorities 4–5) are compiled in.
- FETCH_RAS_EN undefined: no stack storage. Call_en and Ret_en ports remain but are ignored, so those cycles behave per priorities 6–7. StackErr is tied to 0.

## Test plan
- Init=1, ProgSel=1 for 1 cycle, then idle → PC=52,53,…,134. Halt=1 on the cycle after PC=134; PC stays at 134 until Init.
- PC=10, Branch_en=1, FLAG_IN=1, BranchRel=1, Target=10'h3FC (−4) → PC=6. Same request with FLAG_IN=0 → PC=11.
- With FETCH_RAS_EN: call from PC=5 (absolute Target=40), then Ret_en at PC=41 → PC=6 and StackErr=0. Five nested calls with RAS_DEPTH=4 → StackErr=1, and the fifth call's jump is still taken.
- Ret_en with an empty stack at PC=7 → PC=8 and StackErr=1. Without FETCH_RAS_EN, the same stimulus gives PC=8 and StackErr=0.
- Stall=1 for 3 cycles at PC=20 with Branch_en & FLAG_IN asserted → PC holds at 20; the branch is taken on the first cycle with Stall=0.
- PC_W=4, START=4'hE, END=4'h3: run → PC=E,F,0,1,2,3, then Halt. Assert Init while halted → PC=E, Halt=0.
